// File: rtl/conf_tx_packetizer_if.sv
// Valid/ready word link from the configuration packetizer toward the host TX path.
interface conf_tx_packetizer_if #(
  parameter int TX_WIDTH = 8
);
  logic [TX_WIDTH-1:0] tx_data;
  logic                tx_valid;
  logic                tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/conf_tx_packetizer.sv
// Drains the configuration shift register as a HEADER / payload / XOR-checksum frame
// over a valid/ready word link, generating the load and per-word advance pulses.
module conf_tx_packetizer #(
  parameter int                  NUM_REGS   = 2,
  parameter int                  DATA_WIDTH = 16,
  parameter int                  TX_WIDTH   = 8,
  parameter logic [TX_WIDTH-1:0] HEADER     = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  output logic                o_sr_request,
  input  logic [TX_WIDTH-1:0] i_sr_data,
  input  logic                i_sr_empty,
  output logic                o_sr_ack,
  conf_tx_packetizer_if.master tx,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_underrun
);
  localparam int            NUM_WORDS = DATA_WIDTH / TX_WIDTH * NUM_REGS;
  localparam int            CW        = $clog2(NUM_WORDS + 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_DATA,
    S_CHECK
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_count;
  logic [TX_WIDTH-1:0] r_checksum;
  logic                r_done;
  logic                r_underrun;
  logic                w_xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_checksum <= '0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_CHECK) && w_xfer;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_count    <= '0;
            r_checksum <= '0;
            r_underrun <= 1'b0;
          end
        end
        S_DATA: begin
          // Payload is still owed in every DATA cycle, so an empty source here is an underrun.
          if (i_sr_empty) r_underrun <= 1'b1;
          if (w_xfer) begin
            r_checksum <= r_checksum ^ i_sr_data;
            r_count    <= r_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next       = r_state;
    tx.tx_valid  = 1'b0;
    tx.tx_data   = '0;
    o_sr_request = 1'b0;
    o_sr_ack     = 1'b0;
    w_xfer       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_LOAD;
      end
      S_LOAD: begin
        o_sr_request = 1'b1;
        w_next       = S_HEADER;
      end
      S_HEADER: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = HEADER;
        w_xfer      = tx.tx_ready;
        if (w_xfer) w_next = S_DATA;
      end
      S_DATA: begin
        // The advance pulse is tied to the transfer so the next word appears without a bubble.
        tx.tx_valid = 1'b1;
        tx.tx_data  = i_sr_data;
        w_xfer      = tx.tx_ready;
        o_sr_ack    = w_xfer;
        if (w_xfer && (r_count == LAST_WORD)) w_next = S_CHECK;
      end
      S_CHECK: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = r_checksum;
        w_xfer      = tx.tx_ready;
        if (w_xfer) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = r_done;
  assign o_underrun = r_underrun;
endmodule
